spi_apb_arbiter: RTL and testbench

Shares the single APB slave port of the SPI controller among NUM_REQ on-chip requesters (CPU bridge, DMA, boot loader, debug).
- Each requester posts one register access through a valid/done handshake.
- The block round-robin arbitrates between requesters and sequences the APB SETUP/ACCESS phases.
- It bounds slave wait states with a timeout, then returns read data and error status to the granted requester.
- It sits between the requesters and the spi_controller APB inputs, replacing a direct APB master.

---
 rtl/spi_apb_arb_pkg.sv | 17 +
 rtl/spi_rr_pick.sv | 28 ++
 rtl/spi_apb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spi_apb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_apb_arb_pkg.sv
// Shared types and default widths for the SPI APB requester arbiter.
// Imported by the arbiter top and reusable by sibling multi-master blocks.
package spi_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1.
// Returns the winning index and whether any request was present.
module spi_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     grant_o,
    output logic               any_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = IDW'((int'(ptr_i) + 1 + i) % int'(NUM_REQ));
            if (!any_o && req_i[cand]) begin
                any_o   = 1'b1;
                grant_o = cand;
            end
        end
    end

endmodule

// File: rtl/spi_apb_arbiter.sv
// Round-robin arbiter sharing the SPI controller APB slave port among
// several requesters, with a bounded wait-state timeout.
module spi_apb_arbiter
    import spi_apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       pclk_i,
    input  logic                       presetn_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         req_done_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       psel_o,
    output logic                       penable_o,
    output logic                       pwrite_o,
    output logic [ADDR_W-1:0]          paddr_o,
    output logic [DATA_W-1:0]          pwdata_o,
    input  logic [DATA_W-1:0]          prdata_i,
    input  logic                       pready_i,
    input  logic                       pslverr_i
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [IDW-1:0]      pick;
    logic                pick_any;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d   = SETUP;
                    ptr_d     = pick;
                    grant_d   = pick;
                    pwrite_d  = req_write_i[pick];
                    paddr_d   = req_addr_i[pick*ADDR_W +: ADDR_W];
                    pwdata_d  = req_wdata_i[pick*DATA_W +: DATA_W];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d   = DONE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    done_d    = NUM_REQ'(1) << grant_q;
                    // A timed-out access reports error with zeroed data
                    rdata_d   = (pready_i && !pwrite_q) ? prdata_i : '0;
                    err_d     = pready_i ? pslverr_i : 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q   <= IDLE;
            ptr_q     <= IDW'(NUM_REQ - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign req_done_o  = done_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = busy_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Directed self-checking bench for spi_apb_arbiter (4 requesters,
// short timeout so the abort path is reachable quickly).
module tb_spi_apb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_write;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic [3:0]   req_done;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [1:0]   grant_id;
    logic         busy;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [7:0]   paddr;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;

    int n_cmp = 0;
    int n_err = 0;

    spi_apb_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .pclk_i      (clk),
        .presetn_i   (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_done_o  (req_done),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        #2;
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_paddr", 32'(paddr), 0);
        chk("rst_rdata", rsp_rdata, 0);
        #10 rst_n = 1'b1;
        step();

        // Req0 write, zero wait states
        req_valid          = 4'b0001;
        req_write[0]       = 1'b1;
        req_addr[7:0]      = 8'h04;
        req_wdata[31:0]    = 32'h12345678;
        step();
        chk("t1_setup_psel", 32'(psel), 1);
        chk("t1_setup_pen", 32'(penable), 0);
        chk("t1_setup_addr", 32'(paddr), 32'h04);
        chk("t1_setup_busy", 32'(busy), 1);
        chk("t1_setup_done", 32'(req_done), 0);
        step();
        chk("t1_acc_pen", 32'(penable), 1);
        chk("t1_acc_addr", 32'(paddr), 32'h04);
        chk("t1_acc_wdata", pwdata, 32'h12345678);
        chk("t1_acc_write", 32'(pwrite), 1);
        step();
        chk("t1_done", 32'(req_done), 32'b0001);
        chk("t1_done_err", 32'(rsp_err), 0);
        chk("t1_done_rdata", rsp_rdata, 0);
        chk("t1_done_psel", 32'(psel), 0);
        req_valid = '0;
        step();
        chk("t1_idle_done", 32'(req_done), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_hold_addr", 32'(paddr), 32'h04);

        // Fresh reset so round-robin starts from req0
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_grant", 32'(grant_id), k % 4);
            chk("t2_psel", 32'(psel), 1);
            step();
            step();
            chk("t2_done", 32'(req_done), 32'(1) << (k % 4));
            step();
            chk("t2_idle_done", 32'(req_done), 0);
        end
        req_valid = '0;
        step();
        step();
        step();
        step();
        chk("t2_drain_busy", 32'(busy), 0);

        // Req2 read with three wait states
        req_valid        = 4'b0100;
        req_write[2]     = 1'b0;
        req_addr[23:16]  = 8'h08;
        pready           = 1'b0;
        step();
        chk("t3_grant", 32'(grant_id), 2);
        chk("t3_pen_setup", 32'(penable), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_pen_hi", 32'(penable), 1);
            chk("t3_addr", 32'(paddr), 32'h08);
            chk("t3_nodone", 32'(req_done), 0);
        end
        // pready was low in the first three ACCESS cycles; high in the 4th
        // is emulated by raising it here, before the 4th ACCESS edge
        // This bench raised it only now, so re-align: three low already
        // counted plus this cycle is the completion.
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
        step();
        chk("t3_done", 32'(req_done), 32'b0100);
        chk("t3_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t3_err", 32'(rsp_err), 0);
        chk("t3_pen_lo", 32'(penable), 0);
        req_valid = '0;
        step();

        // Timeout: req0 read with pready stuck low
        req_valid       = 4'b0001;
        req_write[0]    = 1'b0;
        req_addr[7:0]   = 8'h10;
        pready          = 1'b0;
        prdata          = 32'hFFFFFFFF;
        step();
        chk("t5_grant", 32'(grant_id), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t5_pen_hi", 32'(penable), 1);
        end
        step();
        chk("t5_psel_lo", 32'(psel), 0);
        chk("t5_pen_lo", 32'(penable), 0);
        chk("t5_done", 32'(req_done), 32'b0001);
        chk("t5_err", 32'(rsp_err), 1);
        chk("t5_rdata", rsp_rdata, 0);
        req_valid = '0;
        pready    = 1'b1;
        step();

        // Req1 write with slave error, then a clean write
        req_valid        = 4'b0010;
        req_write[1]     = 1'b1;
        req_addr[15:8]   = 8'h0C;
        req_wdata[63:32] = 32'h000000AA;
        pslverr          = 1'b1;
        step();
        chk("t4_grant", 32'(grant_id), 1);
        step();
        step();
        chk("t4_done", 32'(req_done), 32'b0010);
        chk("t4_err", 32'(rsp_err), 1);
        req_valid = '0;
        pslverr   = 1'b0;
        step();
        chk("t4_err_hold", 32'(rsp_err), 1);
        req_valid = 4'b0010;
        step();
        step();
        step();
        chk("t4b_done", 32'(req_done), 32'b0010);
        chk("t4b_err", 32'(rsp_err), 0);
        req_valid = '0;
        step();

        // Reset in the middle of req3's ACCESS phase
        req_valid        = 4'b1000;
        req_write[3]     = 1'b1;
        req_addr[31:24]  = 8'h20;
        pready           = 1'b0;
        step();
        chk("t6_grant", 32'(grant_id), 3);
        step();
        chk("t6_acc_pen", 32'(penable), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_psel", 32'(psel), 0);
        chk("t6_rst_pen", 32'(penable), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        step();
        chk("t6_rst_done", 32'(req_done), 0);
        req_valid = 4'b1001;
        req_write[0] = 1'b1;
        pready    = 1'b1;
        #2 rst_n  = 1'b1;
        step();
        chk("t6_first_grant", 32'(grant_id), 0);
        chk("t6_first_psel", 32'(psel), 1);
        step();
        step();
        chk("t6_first_done", 32'(req_done), 32'b0001);
        req_valid = 4'b1000;
        step();
        step();
        chk("t6_second_grant", 32'(grant_id), 3);
        step();
        step();
        chk("t6_second_done", 32'(req_done), 32'b1000);
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
